polyphony_voice_scheduler: RTL and testbench

Controller that owns the polyphony mixer's voice slots and sequences every mixed sample. It allocates incoming note requests to free voice slots, retires them when their beat duration expires, and fans the codec's generate-next request out to the active note players. Once all active voices have delivered, it hands their samples, with idle slots zeroed, to the mixer together with an occupancy-derived multiplier. It sits between the song reader / note players and `polyphony_mixer`.

---
 rtl/polyphony_voice_scheduler_pkg.sv | 23 ++
 rtl/polyphony_voice_scheduler_if.sv | 43 ++++
 rtl/voice_slot_alloc.sv | 126 ++++++++++++
 rtl/polyphony_voice_scheduler.sv | 128 ++++++++++++
 tb/tb_polyphony_voice_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/polyphony_voice_scheduler_pkg.sv
// Shared definitions for the polyphony voice scheduler: default slot count,
// sample width, scheduler FSM states and the occupancy-to-gain table.
package polyphony_pkg;

  localparam int NUM_NOTES_DEFAULT = 3;
  localparam int SAMPLE_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_WAIT     = 3'd2,
    ST_FIRE     = 3'd3,
    ST_WAIT_MIX = 3'd4
  } sched_state_e;

  // Mixer gain for n active voices: silence, full scale, or an even share.
  function automatic logic [7:0] mult_for_count(input int unsigned n);
    if (n == 0)      return 8'd0;
    else if (n == 1) return 8'd255;
    else             return 8'(32'd256 / n);
  endfunction

endpackage

// File: rtl/polyphony_voice_scheduler_if.sv
// Bus bundle between the voice scheduler and its surroundings (song reader,
// note players, mixer). "master" is the scheduler side, "slave" the rest.
interface polyphony_voice_scheduler_if
  import polyphony_pkg::*;
#(
  parameter int NUM_NOTES = NUM_NOTES_DEFAULT,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
);
  logic                          note_valid;
  logic                          note_ready;
  logic [NOTE_W-1:0]             note_id;
  logic [DUR_W-1:0]              note_duration;
  logic                          beat;
  logic                          generate_next;
  logic [NUM_NOTES-1:0]          voice_load;
  logic [NUM_NOTES*NOTE_W-1:0]   voice_note;
  logic [NUM_NOTES-1:0]          voice_active;
  logic [NUM_NOTES-1:0]          voice_generate_next;
  logic [NUM_NOTES-1:0]          voice_sample_ready;
  logic [NUM_NOTES*SAMPLE_W-1:0] voice_samples;
  logic                          mix_samples_ready;
  logic [NUM_NOTES*SAMPLE_W-1:0] mix_samples;
  logic [7:0]                    mix_multiplier;
  logic                          mix_sample_ready;
  logic                          overrun;

  modport master (
    input  note_valid, note_id, note_duration, beat, generate_next,
           voice_sample_ready, voice_samples, mix_sample_ready,
    output note_ready, voice_load, voice_note, voice_active,
           voice_generate_next, mix_samples_ready, mix_samples,
           mix_multiplier, overrun
  );

  modport slave (
    output note_valid, note_id, note_duration, beat, generate_next,
           voice_sample_ready, voice_samples, mix_sample_ready,
    input  note_ready, voice_load, voice_note, voice_active,
           voice_generate_next, mix_samples_ready, mix_samples,
           mix_multiplier, overrun
  );
endinterface

// File: rtl/voice_slot_alloc.sv
// Voice slot array: allocates note requests to the lowest free slot, counts
// down durations on each beat and retires expired slots.
// Optional feature: POLY_VOICE_STEAL_EN -- when full, overwrite the oldest
// slot (round-robin steal pointer) instead of back-pressuring requests.
module voice_slot_alloc
  import polyphony_pkg::*;
#(
  parameter int NUM_NOTES = NUM_NOTES_DEFAULT,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        note_valid_i,
  input  logic [NOTE_W-1:0]           note_id_i,
  input  logic [DUR_W-1:0]            note_duration_i,
  input  logic                        beat_i,
  output logic                        note_ready_o,
  output logic [NUM_NOTES-1:0]        voice_load_o,
  output logic [NUM_NOTES*NOTE_W-1:0] voice_note_o,
  output logic [NUM_NOTES-1:0]        voice_active_o
);
  localparam int IDX_W = $clog2(NUM_NOTES);

  logic [NUM_NOTES-1:0] active_q, active_d;
  logic [NUM_NOTES-1:0] load_q, load_d;
  logic [DUR_W-1:0]     dur_q  [NUM_NOTES];
  logic [DUR_W-1:0]     dur_d  [NUM_NOTES];
  logic [NOTE_W-1:0]    note_q [NUM_NOTES];
  logic [NOTE_W-1:0]    note_d [NUM_NOTES];
  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     target_idx;
  logic                 alloc;

  // Priority encoder: lowest-indexed free slot wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path infers a latch.
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

`ifdef POLY_VOICE_STEAL_EN
  logic [IDX_W-1:0] steal_ptr_q, steal_ptr_d;

  assign note_ready_o = 1'b1;
  assign target_idx   = any_free ? free_idx : steal_ptr_q;

  // Steal pointer tracks the oldest slot: it advances on every allocation.
  always_comb begin
    steal_ptr_d = steal_ptr_q;
    if (alloc) begin
      steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_NOTES - 1)) ? '0 : steal_ptr_q + IDX_W'(1);
    end
  end

  // Steal pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) steal_ptr_q <= '0;
    else        steal_ptr_q <= steal_ptr_d;
  end
`else
  assign note_ready_o = any_free;
  assign target_idx   = free_idx;
`endif

  // Rests (duration 0) are accepted but never occupy a slot.
  assign alloc = note_valid_i & note_ready_o & (note_duration_i != '0);

  // Per-slot next state: a fresh allocation overrides the beat decrement.
  always_comb begin
    active_d = active_q;
    load_d   = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      dur_d[i]  = dur_q[i];
      note_d[i] = note_q[i];
      if (alloc && (target_idx == IDX_W'(i))) begin
        dur_d[i]    = note_duration_i;
        note_d[i]   = note_id_i;
        active_d[i] = 1'b1;
        load_d[i]   = 1'b1;
      end else if (beat_i && active_q[i]) begin
        dur_d[i] = dur_q[i] - DUR_W'(1);
        if (dur_q[i] == DUR_W'(1)) active_d[i] = 1'b0;
      end
    end
  end

  // NOTE: state registers use <= so every flop sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
      load_q   <= '0;
      // NOTE: the slot arrays are a handful of flops that must come up empty, so they are reset like any other register.
      for (int i = 0; i < NUM_NOTES; i++) begin
        dur_q[i]  <= '0;
        note_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      load_q   <= load_d;
      for (int i = 0; i < NUM_NOTES; i++) begin
        dur_q[i]  <= dur_d[i];
        note_q[i] <= note_d[i];
      end
    end
  end

  // Flatten per-slot note ids for the note players.
  always_comb begin
    voice_note_o = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      voice_note_o[i*NOTE_W +: NOTE_W] = note_q[i];
    end
  end

  assign voice_load_o   = load_q;
  assign voice_active_o = active_q;

endmodule

// File: rtl/polyphony_voice_scheduler.sv
// Polyphony voice scheduler top: slot allocation (voice_slot_alloc) plus the
// sample sequencing FSM that fans generate_next out to active voices, gathers
// their samples and hands them to the mixer with an occupancy-derived gain.
// Optional feature: POLY_VOICE_STEAL_EN (voice stealing, in voice_slot_alloc).
module polyphony_voice_scheduler
  import polyphony_pkg::*;
#(
  parameter int NUM_NOTES = NUM_NOTES_DEFAULT,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input logic                        clk,
  input logic                        reset,
  polyphony_voice_scheduler_if.master bus
);
  logic [NUM_NOTES-1:0]          voice_active;
  sched_state_e                  state_q;
  logic [NUM_NOTES-1:0]          mask_q, done_q, vgen_q;
  logic [SAMPLE_W-1:0]           cap_q [NUM_NOTES];
  logic [NUM_NOTES*SAMPLE_W-1:0] mix_samples_q;
  logic                          mix_ready_q, overrun_q;
  logic [7:0]                    mult_q;
  int unsigned                   active_cnt;
  logic [NUM_NOTES-1:0]          hit;
  logic                          done_all;
  logic [NUM_NOTES*SAMPLE_W-1:0] merged;

  voice_slot_alloc #(
    .NUM_NOTES(NUM_NOTES),
    .NOTE_W   (NOTE_W),
    .DUR_W    (DUR_W)
  ) u_alloc (
    .clk            (clk),
    .reset          (reset),
    .note_valid_i   (bus.note_valid),
    .note_id_i      (bus.note_id),
    .note_duration_i(bus.note_duration),
    .beat_i         (bus.beat),
    .note_ready_o   (bus.note_ready),
    .voice_load_o   (bus.voice_load),
    .voice_note_o   (bus.voice_note),
    .voice_active_o (voice_active)
  );

  // Number of occupied slots, used for the mixer gain at snapshot time.
  always_comb begin
    active_cnt = 0;
    for (int i = 0; i < NUM_NOTES; i++) active_cnt = active_cnt + 32'(voice_active[i]);
  end

  assign hit      = bus.voice_sample_ready & mask_q;
  assign done_all = ((done_q | hit) == mask_q);

  // Samples as they will look once this cycle's arrivals are included.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      merged[i*SAMPLE_W +: SAMPLE_W] = hit[i] ? bus.voice_samples[i*SAMPLE_W +: SAMPLE_W] : cap_q[i];
    end
  end

  // Sequencing FSM with registered outputs; cap_q is cleared at snapshot so
  // slots outside the mask always reach the mixer as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mask_q        <= '0;
      done_q        <= '0;
      vgen_q        <= '0;
      mix_samples_q <= '0;
      mix_ready_q   <= 1'b0;
      mult_q        <= '0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_NOTES; i++) cap_q[i] <= '0;
    end else begin
      mix_ready_q <= 1'b0;
      if (bus.generate_next && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (bus.generate_next) begin
            mask_q  <= voice_active;
            done_q  <= '0;
            vgen_q  <= voice_active;
            mult_q  <= mult_for_count(active_cnt);
            for (int i = 0; i < NUM_NOTES; i++) cap_q[i] <= '0;
            state_q <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          vgen_q <= '0;
          if (mask_q == '0) begin
            mix_samples_q <= '0;
            mix_ready_q   <= 1'b1;
            state_q       <= ST_FIRE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          for (int i = 0; i < NUM_NOTES; i++) begin
            if (hit[i]) cap_q[i] <= bus.voice_samples[i*SAMPLE_W +: SAMPLE_W];
          end
          done_q <= done_q | hit;
          if (done_all) begin
            mix_samples_q <= merged;
            mix_ready_q   <= 1'b1;
            state_q       <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          state_q <= ST_WAIT_MIX;
        end
        ST_WAIT_MIX: begin
          if (bus.mix_sample_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.voice_active        = voice_active;
  assign bus.voice_generate_next = vgen_q;
  assign bus.mix_samples_ready   = mix_ready_q;
  assign bus.mix_samples         = mix_samples_q;
  assign bus.mix_multiplier      = mult_q;
  assign bus.overrun             = overrun_q;

endmodule

// File: tb/tb_polyphony_voice_scheduler.sv
// Self-checking bench for polyphony_voice_scheduler: a table of allocation
// vectors, hand-written sequences for the mixer handshake corner cases, and
// randomized traffic checked against a slot-level reference model.
module tb_polyphony_voice_scheduler;
  import polyphony_pkg::*;

  localparam int N  = 3;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int SW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  polyphony_voice_scheduler_if #(.NUM_NOTES(N), .NOTE_W(NW), .DUR_W(DW)) bus ();

  polyphony_voice_scheduler #(.NUM_NOTES(N), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: remaining beats per slot (0 = free), note per slot.
  int             m_dur  [N];
  int             m_note [N];
  logic [N-1:0]   m_load;
  int             m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
`ifdef POLY_VOICE_STEAL_EN
    return 1'b1;
`else
    foreach (m_dur[i]) if (m_dur[i] == 0) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_dur[i]) begin m_dur[i] = 0; m_note[i] = 0; end
    m_load = '0;
    m_ptr  = 0;
  endtask

  // Applies the spec rules for one clock edge using the inputs now on the bus.
  task automatic model_edge();
    int tgt;
    tgt    = -1;
    m_load = '0;
    if (bus.note_valid && m_ready() && bus.note_duration != 0) begin
      for (int i = 0; i < N; i++) if (m_dur[i] == 0) begin tgt = i; break; end
`ifdef POLY_VOICE_STEAL_EN
      if (tgt < 0) tgt = m_ptr;
      m_ptr = (m_ptr + 1) % N;
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (i == tgt) begin
        m_dur[i]  = int'(bus.note_duration);
        m_note[i] = int'(bus.note_id);
        m_load[i] = 1'b1;
      end else if (bus.beat && m_dur[i] > 0) begin
        m_dur[i] = m_dur[i] - 1;
      end
    end
  endtask

  function automatic logic [N-1:0] m_active();
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) a[i] = (m_dur[i] != 0);
    return a;
  endfunction

  function automatic logic [N*NW-1:0] m_notes();
    logic [N*NW-1:0] v;
    for (int i = 0; i < N; i++) v[i*NW +: NW] = NW'(m_note[i]);
    return v;
  endfunction

  function automatic logic [7:0] exp_mult(input int n);
    if (n == 0) return 8'd0;
    if (n == 1) return 8'd255;
    return 8'(256 / n);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    bus.note_valid         = 1'b0;
    bus.note_id            = '0;
    bus.note_duration      = '0;
    bus.beat               = 1'b0;
    bus.generate_next      = 1'b0;
    bus.voice_sample_ready = '0;
    bus.voice_samples      = '0;
    bus.mix_sample_ready   = 1'b0;
  endtask

  task automatic check_alloc(input string tag);
    check({tag, ".active"}, 64'(bus.voice_active), 64'(m_active()));
    check({tag, ".note"},   64'(bus.voice_note),   64'(m_notes()));
    check({tag, ".load"},   64'(bus.voice_load),   64'(m_load));
    check({tag, ".ready"},  64'(bus.note_ready),   64'(m_ready()));
  endtask

  // Asserts reset mid-cycle and checks outputs react without a clock edge.
  task automatic do_reset(input string tag);
    quiet();
    reset = 1'b0;
    #2;
    check({tag, ".note_ready"}, 64'(bus.note_ready), 64'd1);
    check({tag, ".active"},     64'(bus.voice_active), 64'd0);
    check({tag, ".note"},       64'(bus.voice_note), 64'd0);
    check({tag, ".load"},       64'(bus.voice_load), 64'd0);
    check({tag, ".vgen"},       64'(bus.voice_generate_next), 64'd0);
    check({tag, ".mix_ready"},  64'(bus.mix_samples_ready), 64'd0);
    check({tag, ".mix_samp"},   64'(bus.mix_samples), 64'd0);
    check({tag, ".mult"},       64'(bus.mix_multiplier), 64'd0);
    check({tag, ".overrun"},    64'(bus.overrun), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic          valid;
    logic [NW-1:0] id;
    logic [DW-1:0] dur;
    logic          beat;
    logic [N-1:0]  act;
    logic [N-1:0]  load;
    logic          ready;
    logic [N*NW-1:0] notes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0]    mask;
    logic [N*SW-1:0] exp_s;
    int              cnt, maxd;
    int              dly [N];
    logic [SW-1:0]   smp [N];

    // Fill-to-full table; the fourth request stalls or steals.
    vecs[0] = '{1'b1, 6'd10, 6'd1, 1'b0, 3'b001, 3'b001, 1'b1, {6'd0,  6'd0,  6'd10}};
    vecs[1] = '{1'b1, 6'd20, 6'd1, 1'b0, 3'b011, 3'b010, 1'b1, {6'd0,  6'd20, 6'd10}};
    vecs[2] = '{1'b1, 6'd30, 6'd1, 1'b0, 3'b111, 3'b100, 1'b0, {6'd30, 6'd20, 6'd10}};
`ifdef POLY_VOICE_STEAL_EN
    vecs[2].ready = 1'b1;
    vecs[3] = '{1'b1, 6'd40, 6'd2, 1'b0, 3'b111, 3'b001, 1'b1, {6'd30, 6'd20, 6'd40}};
    vecs[4] = '{1'b1, 6'd50, 6'd1, 1'b0, 3'b111, 3'b010, 1'b1, {6'd30, 6'd50, 6'd40}};
    vecs[5] = '{1'b0, 6'd0,  6'd0, 1'b1, 3'b001, 3'b000, 1'b1, {6'd30, 6'd50, 6'd40}};
`else
    vecs[3] = '{1'b1, 6'd40, 6'd2, 1'b0, 3'b111, 3'b000, 1'b0, {6'd30, 6'd20, 6'd10}};
    vecs[4] = '{1'b1, 6'd40, 6'd2, 1'b1, 3'b000, 3'b000, 1'b1, {6'd30, 6'd20, 6'd10}};
    vecs[5] = '{1'b1, 6'd40, 6'd2, 1'b0, 3'b001, 3'b001, 1'b1, {6'd30, 6'd20, 6'd40}};
`endif

    quiet();
    model_reset();
    do_reset("reset0");

    for (int v = 0; v < 6; v++) begin
      bus.note_valid    = vecs[v].valid;
      bus.note_id       = vecs[v].id;
      bus.note_duration = vecs[v].dur;
      bus.beat          = vecs[v].beat;
      tick();
      check($sformatf("vec%0d.active", v), 64'(bus.voice_active), 64'(vecs[v].act));
      check($sformatf("vec%0d.load", v),   64'(bus.voice_load),   64'(vecs[v].load));
      check($sformatf("vec%0d.ready", v),  64'(bus.note_ready),   64'(vecs[v].ready));
      check($sformatf("vec%0d.notes", v),  64'(bus.voice_note),   64'(vecs[v].notes));
    end

    // Two voices, samples returned in different cycles, stray ready outside mask.
    do_reset("reset1");
    bus.note_valid = 1'b1; bus.note_id = 6'd3; bus.note_duration = 6'd1; tick();
    bus.note_id = 6'd4; tick();
    quiet();
    bus.generate_next = 1'b1; tick(); bus.generate_next = 1'b0;
    check("mix2.vgen", 64'(bus.voice_generate_next), 64'b011);
    check("mix2.mult", 64'(bus.mix_multiplier), 64'd128);
    tick();
    check("mix2.vgen_drop", 64'(bus.voice_generate_next), 64'd0);
    bus.voice_sample_ready = 3'b101;
    bus.voice_samples      = {16'd999, 16'hBEEF, 16'd12000};
    tick();
    check("mix2.early", 64'(bus.mix_samples_ready), 64'd0);
    bus.voice_sample_ready = 3'b000;
    bus.voice_samples      = {16'd1, 16'd2, 16'd3};
    tick();
    check("mix2.gap", 64'(bus.mix_samples_ready), 64'd0);
    bus.voice_sample_ready = 3'b010;
    bus.voice_samples      = {16'd777, 16'd25000, 16'd5};
    tick();
    bus.voice_sample_ready = 3'b000;
    check("mix2.fire", 64'(bus.mix_samples_ready), 64'd1);
    check("mix2.samples", 64'(bus.mix_samples), 64'({16'd0, 16'd25000, 16'd12000}));
    tick();
    check("mix2.one_pulse", 64'(bus.mix_samples_ready), 64'd0);
    bus.mix_sample_ready = 1'b1; tick(); bus.mix_sample_ready = 1'b0;
    check("mix2.overrun", 64'(bus.overrun), 64'd0);

    // Empty mask after the voices retire.
    bus.beat = 1'b1; tick(); bus.beat = 1'b0;
    check("empty.retired", 64'(bus.voice_active), 64'd0);
    bus.generate_next = 1'b1; tick(); bus.generate_next = 1'b0;
    check("empty.vgen", 64'(bus.voice_generate_next), 64'd0);
    check("empty.t1", 64'(bus.mix_samples_ready), 64'd0);
    tick();
    check("empty.t2", 64'(bus.mix_samples_ready), 64'd1);
    check("empty.mult", 64'(bus.mix_multiplier), 64'd0);
    check("empty.samples", 64'(bus.mix_samples), 64'd0);
    tick();
    bus.mix_sample_ready = 1'b1; tick(); bus.mix_sample_ready = 1'b0;

    // generate_next during WAIT sets overrun; reset in WAIT clears everything.
    bus.note_valid = 1'b1; bus.note_id = 6'd9; bus.note_duration = 6'd4; tick();
    quiet();
    bus.generate_next = 1'b1; tick(); bus.generate_next = 1'b0;
    check("ovr.vgen", 64'(bus.voice_generate_next), 64'b001);
    check("ovr.mult", 64'(bus.mix_multiplier), 64'd255);
    tick();
    bus.generate_next = 1'b1; tick(); bus.generate_next = 1'b0;
    check("ovr.flag", 64'(bus.overrun), 64'd1);
    check("ovr.no_vgen", 64'(bus.voice_generate_next), 64'd0);
    tick();
    check("ovr.sticky", 64'(bus.overrun), 64'd1);
    do_reset("reset_wait");

    // Beat and allocation together: slot 0 retires, new note lands in slot 1 undecremented.
    bus.note_valid = 1'b1; bus.note_id = 6'd5; bus.note_duration = 6'd1; tick();
    bus.note_id = 6'd7; bus.note_duration = 6'd3; bus.beat = 1'b1; tick();
    check("beat_alloc.active", 64'(bus.voice_active), 64'b010);
    check("beat_alloc.load",   64'(bus.voice_load), 64'b010);
    check("beat_alloc.note1",  64'(bus.voice_note[NW +: NW]), 64'd7);
    bus.note_valid = 1'b0;
    tick(); tick();
    check("beat_alloc.dur_left", 64'(bus.voice_active), 64'b010);
    tick();
    check("beat_alloc.expired", 64'(bus.voice_active), 64'b000);

    // Randomized allocation traffic interleaved with full mix transactions.
    do_reset("reset_rand");
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 25; c++) begin
        bus.note_valid    = ($urandom_range(0, 9) < 6);
        bus.note_id       = NW'($urandom_range(0, 63));
        bus.note_duration = DW'($urandom_range(0, 3));
        bus.beat          = ($urandom_range(0, 3) == 0);
        tick();
        check_alloc($sformatf("rnd%0d_%0d", r, c));
      end
      quiet();
      mask = m_active();
      cnt  = $countones(mask);
      bus.generate_next = 1'b1; tick(); bus.generate_next = 1'b0;
      check($sformatf("rmix%0d.vgen", r), 64'(bus.voice_generate_next), 64'(mask));
      check($sformatf("rmix%0d.mult", r), 64'(bus.mix_multiplier), 64'(exp_mult(cnt)));
      maxd = 0;
      exp_s = '0;
      for (int i = 0; i < N; i++) begin
        dly[i] = mask[i] ? int'($urandom_range(1, 4)) : 0;
        smp[i] = SW'($urandom);
        if (dly[i] > maxd) maxd = dly[i];
        if (mask[i]) exp_s[i*SW +: SW] = smp[i];
      end
      tick();
      if (mask == '0) begin
        check($sformatf("rmix%0d.empty_fire", r), 64'(bus.mix_samples_ready), 64'd1);
        check($sformatf("rmix%0d.empty_samp", r), 64'(bus.mix_samples), 64'd0);
      end else begin
        for (int k = 1; k <= 4; k++) begin
          for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
              bus.voice_sample_ready[i] = (dly[i] == k);
              bus.voice_samples[i*SW +: SW] = (dly[i] == k) ? smp[i] : SW'($urandom);
            end else begin
              bus.voice_sample_ready[i] = 1'($urandom_range(0, 1));
              bus.voice_samples[i*SW +: SW] = SW'($urandom);
            end
          end
          tick();
          check($sformatf("rmix%0d.ready_k%0d", r, k), 64'(bus.mix_samples_ready), 64'(k == maxd));
          if (k == maxd) check($sformatf("rmix%0d.samples", r), 64'(bus.mix_samples), 64'(exp_s));
        end
      end
      quiet();
      tick();
      check($sformatf("rmix%0d.after", r), 64'(bus.mix_samples_ready), 64'd0);
      bus.mix_sample_ready = 1'b1; tick(); bus.mix_sample_ready = 1'b0;
      check($sformatf("rmix%0d.overrun", r), 64'(bus.overrun), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
